// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache controller.
// Holds the controller state encoding, the default geometry, the derived
// index/tag widths and a saturating increment used by the statistics counters.
package dcache_pkg;

    localparam int NUM_LINES_DEF = 16;
    localparam int ADDR_W_DEF    = 32;
    localparam int INDEX_W       = $clog2(NUM_LINES_DEF);
    localparam int TAG_W         = ADDR_W_DEF - INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        WRITE_MEM,
        RESP
    } state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dcache_store.sv
// Line storage for the direct-mapped cache: data, tag and valid arrays.
// Ports:
//   clk_i, reset_i      : clock and synchronous active-high reset (valid bits only)
//   rd_idx_i            : combinational read index
//   rd_valid_o/tag/data : contents of the addressed line
//   wr_en_i, wr_idx_i   : single synchronous write port; a write also sets valid
//   wr_tag_i, wr_data_i : tag and data written into the line
module dcache_store
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEF,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TG_W      = ADDR_W_DEF - IDX_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TG_W-1:0]  rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TG_W-1:0]  wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TG_W-1:0]      tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tags and data are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, write-allocate data cache controller.
// One 32-bit word per line; memory is always current, so evictions never
// write back.
// Ports:
//   clk, reset                 : clock and synchronous active-high reset
//   cpu_req/we/addr/wdata      : CPU request, held until cpu_ready
//   cpu_ready, cpu_rdata       : one-cycle completion pulse with read data
//   cache_hit, cache_miss      : one-cycle lookup result pulses
//   mem_req/we/addr/wdata      : memory request, held stable until mem_ack
//   mem_ack, mem_rdata         : memory completion pulse with read data
//   hit_count, miss_count      : saturating statistics counters
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              cache_hit,
    output logic              cache_miss,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TG_W  = ADDR_W - IDX_W;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              cpu_ready_q;
    logic              hit_q;
    logic              miss_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       hit_cnt_q;
    logic [31:0]       miss_cnt_q;

    logic              line_valid;
    logic [TG_W-1:0]   line_tag;
    logic [31:0]       line_data;
    logic              lookup_hit;
    logic              wr_en_d;
    logic [31:0]       wr_data_d;

    wire [IDX_W-1:0] idx = addr_q[IDX_W-1:0];
    wire [TG_W-1:0]  tag = addr_q[ADDR_W-1:IDX_W];

    dcache_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TG_W      (TG_W)
    ) u_store (
        .clk_i      (clk),
        .reset_i    (reset),
        .rd_idx_i   (idx),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_en_i    (wr_en_d),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_data_i  (wr_data_d)
    );

    assign lookup_hit = line_valid && (line_tag == tag);

    // Line writes: write-allocate during LOOKUP of a write, refill when the
    // memory read completes. Suppressed under reset so an abandoned fill
    // leaves nothing behind.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_data_d = mem_rdata;
        if (!reset) begin
            if (state_q == LOOKUP && we_q) begin
                wr_en_d   = 1'b1;
                wr_data_d = wdata_q;
            end else if (state_q == FILL && mem_ack) begin
                wr_en_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cpu_ready_q <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // Captured once here so it stays fixed for the whole request.
                    mem_addr_q <= addr_q;
                    if (we_q) begin
                        hit_q       <= lookup_hit;
                        if (lookup_hit) hit_cnt_q <= sat_inc(hit_cnt_q);
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= wdata_q;
                        state_q     <= WRITE_MEM;
                    end else if (lookup_hit) begin
                        hit_q       <= 1'b1;
                        hit_cnt_q   <= sat_inc(hit_cnt_q);
                        rdata_q     <= line_data;
                        cpu_ready_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        miss_q      <= 1'b1;
                        miss_cnt_q  <= sat_inc(miss_cnt_q);
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        rdata_q     <= mem_rdata;
                        mem_req_q   <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                WRITE_MEM: begin
                    if (mem_ack) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    // cpu_ready is high for this single cycle.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ready  = cpu_ready_q;
    assign cpu_rdata  = rdata_q;
    assign cache_hit  = hit_q;
    assign cache_miss = miss_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cache_hit, cache_miss;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count, miss_count;

    dcache_ctrl #(.NUM_LINES(16), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cache_hit  (cache_hit),
        .cache_miss (cache_miss),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory model, owned by the responder process.
    logic [31:0] mem_model [256];
    int          mem_lat = 1;
    int          stray_req = 0;
    int          stray_done = 0;

    // Observation counters, owned by the monitor process.
    int          ready_cnt = 0, hit_cnt = 0, miss_cnt = 0, req_cycles = 0, unst_cnt = 0;
    logic        prev_req = 1'b0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic        cap_we = 1'b0;

    // Memory responder: acks after mem_lat cycles of mem_req.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'(i) * 3 + 7;
        mem_model[32] = 100;
        mem_model[48] = 32'h0000_1234;
        mem_model[64] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (stray_req != stray_done) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
                stray_done++;
            end else if (mem_req) begin
                cnt++;
                if (cnt > mem_lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_model[mem_addr[7:0]];
                    if (mem_we) mem_model[mem_addr[7:0]] = mem_wdata;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: counts pulses and checks request stability mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (cpu_ready)  ready_cnt++;
            if (cache_hit)  hit_cnt++;
            if (cache_miss) miss_cnt++;
            if (mem_req) begin
                req_cycles++;
                if (!prev_req) begin
                    cap_addr  = mem_addr;
                    cap_we    = mem_we;
                    cap_wdata = mem_wdata;
                end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                    unst_cnt++;
                end
            end
            prev_req = mem_req;
        end
    end

    logic [31:0] rd;
    int lat, nrdy, nhit, nmiss, nreq, nunst;

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int r0, h0, m0, q0, u0;
        @(negedge clk);
        r0 = ready_cnt; h0 = hit_cnt; m0 = miss_cnt; q0 = req_cycles; u0 = unst_cnt;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ready && lat < 100);
        rd = cpu_rdata;
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        nrdy = ready_cnt - r0; nhit = hit_cnt - h0; nmiss = miss_cnt - m0;
        nreq = req_cycles - q0; nunst = unst_cnt - u0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        tests++; if ({cpu_ready, cache_hit, cache_miss} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b expected 000", {cpu_ready, cache_hit, cache_miss}); end
        tests++; if ({mem_req, mem_we} !== 2'b00) begin fails++; $display("FAIL reset_mem: got %b expected 00", {mem_req, mem_we}); end
        tests++; if (hit_count !== 0 || miss_count !== 0) begin fails++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", hit_count, miss_count); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        mem_lat = 1;
        access(1'b0, 32, 0);
        tests++; if (nmiss !== 1 || nhit !== 0) begin fails++; $display("FAIL miss_pulse: got miss=%0d hit=%0d expected 1/0", nmiss, nhit); end
        tests++; if (nreq !== 2 || cap_we !== 1'b0 || cap_addr !== 32) begin fails++; $display("FAIL miss_memreq: got cyc=%0d we=%b addr=%0d expected 2/0/32", nreq, cap_we, cap_addr); end
        tests++; if (rd !== 100) begin fails++; $display("FAIL miss_rdata: got %0d expected 100", rd); end
        tests++; if (lat !== 4 || nrdy !== 1) begin fails++; $display("FAIL miss_ready: got lat=%0d rdy=%0d expected 4/1", lat, nrdy); end
        tests++; if (miss_count !== 1 || hit_count !== 0) begin fails++; $display("FAIL miss_counts: got %0d/%0d expected 1/0", miss_count, hit_count); end
    endtask

    task automatic test_read_hit();
        access(1'b0, 32, 0);
        tests++; if (nhit !== 1 || nmiss !== 0 || nreq !== 0) begin fails++; $display("FAIL hit_pulse: got hit=%0d miss=%0d req=%0d expected 1/0/0", nhit, nmiss, nreq); end
        tests++; if (rd !== 100) begin fails++; $display("FAIL hit_rdata: got %0d expected 100", rd); end
        tests++; if (lat !== 2 || nrdy !== 1) begin fails++; $display("FAIL hit_latency: got lat=%0d rdy=%0d expected 2/1", lat, nrdy); end
        tests++; if (hit_count !== 1) begin fails++; $display("FAIL hit_count: got %0d expected 1", hit_count); end
    endtask

    task automatic test_write();
        access(1'b1, 64, 500);
        tests++; if (cap_we !== 1'b1 || cap_addr !== 64 || cap_wdata !== 500) begin fails++; $display("FAIL wr_mem: got we=%b addr=%0d data=%0d expected 1/64/500", cap_we, cap_addr, cap_wdata); end
        tests++; if (mem_model[64] !== 500 || nrdy !== 1 || nunst !== 0) begin fails++; $display("FAIL wr_done: got mem=%0d rdy=%0d unst=%0d expected 500/1/0", mem_model[64], nrdy, nunst); end
        tests++; if (nhit !== 0 || nmiss !== 0 || miss_count !== 1 || hit_count !== 1) begin fails++; $display("FAIL wr_miss_flags: got hit=%0d miss=%0d cnt=%0d/%0d expected 0/0/1/1", nhit, nmiss, miss_count, hit_count); end
        access(1'b0, 64, 0);
        tests++; if (nhit !== 1 || nreq !== 0 || rd !== 500 || hit_count !== 2) begin fails++; $display("FAIL wr_readback: got hit=%0d req=%0d data=%0d cnt=%0d expected 1/0/500/2", nhit, nreq, rd, hit_count); end
    endtask

    task automatic test_stray_ack();
        int r0;
        @(negedge clk);
        r0 = ready_cnt;
        stray_req++;
        repeat (4) @(negedge clk);
        #2;
        tests++; if (ready_cnt - r0 !== 0 || mem_req !== 1'b0) begin fails++; $display("FAIL stray_ack: got rdy=%0d req=%b expected 0/0", ready_cnt - r0, mem_req); end
        access(1'b0, 64, 0);
        tests++; if (nhit !== 1 || rd !== 500 || hit_count !== 3) begin fails++; $display("FAIL stray_after: got hit=%0d data=%h cnt=%0d expected 1/500/3", nhit, rd, hit_count); end
    endtask

    task automatic test_conflict();
        access(1'b0, 32, 0);
        tests++; if (nmiss !== 1 || nreq !== 2 || rd !== 100 || miss_count !== 2) begin fails++; $display("FAIL conflict: got miss=%0d req=%0d data=%0d cnt=%0d expected 1/2/100/2", nmiss, nreq, rd, miss_count); end
    endtask

    task automatic test_write_hit();
        access(1'b1, 32, 777);
        tests++; if (nhit !== 1 || hit_count !== 4 || mem_model[32] !== 777) begin fails++; $display("FAIL wr_hit: got hit=%0d cnt=%0d mem=%0d expected 1/4/777", nhit, hit_count, mem_model[32]); end
        access(1'b0, 32, 0);
        tests++; if (nhit !== 1 || rd !== 777 || hit_count !== 5) begin fails++; $display("FAIL wr_hit_read: got hit=%0d data=%0d cnt=%0d expected 1/777/5", nhit, rd, hit_count); end
    endtask

    task automatic test_slow_ack();
        mem_lat = 5;
        access(1'b0, 48, 0);
        tests++; if (nreq !== 6 || nunst !== 0 || cap_addr !== 48) begin fails++; $display("FAIL slow_hold: got cyc=%0d unst=%0d addr=%0d expected 6/0/48", nreq, nunst, cap_addr); end
        tests++; if (nrdy !== 1 || lat !== 8 || rd !== 32'h1234) begin fails++; $display("FAIL slow_resp: got rdy=%0d lat=%0d data=%h expected 1/8/1234", nrdy, lat, rd); end
        tests++; if (miss_count !== 3) begin fails++; $display("FAIL slow_count: got %0d expected 3", miss_count); end
        mem_lat = 1;
    endtask

    task automatic test_reset_mid_fill();
        int r0, n;
        mem_lat = 1000;
        @(negedge clk);
        r0 = ready_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 80; cpu_wdata = 0;
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL midfill_start: got req=%b expected 1", mem_req); end
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        tests++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin fails++; $display("FAIL midfill_abort: got req=%b rdy=%b expected 0/0", mem_req, cpu_ready); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        tests++; if (ready_cnt - r0 !== 0 || mem_req !== 1'b0) begin fails++; $display("FAIL midfill_quiet: got rdy=%0d req=%b expected 0/0", ready_cnt - r0, mem_req); end
        mem_lat = 1;
        access(1'b0, 32, 0);
        tests++; if (nmiss !== 1 || nhit !== 0 || rd !== 777 || miss_count !== 1 || hit_count !== 0) begin fails++; $display("FAIL midfill_reread: got miss=%0d hit=%0d data=%0d cnt=%0d/%0d expected 1/0/777/1/0", nmiss, nhit, rd, miss_count, hit_count); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write();
        test_stray_ack();
        test_conflict();
        test_write_hit();
        test_slow_ack();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
